// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants and types for router 0
package router_pkg;

    localparam int FLIT_WIDTH = 32;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        DIR_L = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2
    } dir_e;

endpackage

// File: rtl/router_0_output_port_if.sv
// rtl/router_0_output_port_if.sv - crossbar-side and link-side handshake bundle
import router_pkg::*;

interface router_0_output_port_if #(
    parameter int DATA_WIDTH = FLIT_WIDTH
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  ready_out;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  ready_in;

    modport master (
        output wr_en, data_in, ready_in,
        input  ready_out, valid_out, data_out
    );

    modport slave (
        input  wr_en, data_in, ready_in,
        output ready_out, valid_out, data_out
    );
endinterface

// File: rtl/router_fifo_mem.sv
// rtl/router_fifo_mem.sv - register array, one sync write port, one async read port
import router_pkg::*;

module router_fifo_mem #(
    parameter int DATA_WIDTH = FLIT_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int PW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/router_0_output_port.sv
// rtl/router_0_output_port.sv - FWFT output buffer driving one inter-router link
import router_pkg::*;

module router_0_output_port #(
    parameter int DATA_WIDTH   = FLIT_WIDTH,
    parameter int DEPTH        = FIFO_DEPTH,
    parameter int AFULL_MARGIN = 0,
    localparam int CW          = $clog2(DEPTH + 1),
    localparam int PW          = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    router_0_output_port_if.slave   link,
    output logic [CW-1:0]           count,
    output logic                    overflow
);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] RDY_LIMIT = CW'(DEPTH - 1 - AFULL_MARGIN);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_next;
    logic          wr_accept;
    logic          wr_drop;
    logic          rd_done;
    logic          ready_q;

    // A read in the same cycle never frees a slot for a write on a full FIFO.
    assign wr_accept = link.wr_en && (count != FULL_CNT);
    assign wr_drop   = link.wr_en && (count == FULL_CNT);
    assign rd_done   = link.valid_out && link.ready_in;

    always_comb begin
        count_next = count;
        if (wr_accept && !rd_done) begin
            count_next = count + CW'(1);
        end else if (!wr_accept && rd_done) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_done) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wr_drop) begin
                overflow <= 1'b1;
            end
            count   <= count_next;
            ready_q <= (count_next <= RDY_LIMIT);
        end
    end

    router_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PW         (PW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_accept && rst),
        .waddr (wr_ptr),
        .wdata (link.data_in),
        .raddr (rd_ptr),
        .rdata (link.data_out)
    );

    assign link.valid_out = (count != '0);
    assign link.ready_out = ready_q;
endmodule

// File: tb/tb_router_0_output_port.sv
// tb/tb_router_0_output_port.sv - directed table and sequence checks for the output port
import router_pkg::*;

module tb_router_0_output_port;
    localparam logic L0 = 1'b0;
    localparam logic L1 = 1'b1;

    logic       clk;
    logic       rst;
    logic       rst_m;
    logic [2:0] cnt;
    logic [2:0] cnt_m;
    logic       ovf;
    logic       ovf_m;

    router_0_output_port_if #(.DATA_WIDTH(32)) lk ();
    router_0_output_port_if #(.DATA_WIDTH(32)) lk_m ();

    router_0_output_port #(.DATA_WIDTH(32), .DEPTH(4), .AFULL_MARGIN(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .link     (lk.slave),
        .count    (cnt),
        .overflow (ovf)
    );

    router_0_output_port #(.DATA_WIDTH(32), .DEPTH(4), .AFULL_MARGIN(1)) dut_m (
        .clk      (clk),
        .rst      (rst_m),
        .link     (lk_m.slave),
        .count    (cnt_m),
        .overflow (ovf_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        wr;
        logic [31:0] din;
        logic        ri;
        logic [2:0]  e_cnt;
        logic        e_ro;
        logic        e_v;
        logic [31:0] e_dat;
        logic        e_ov;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] q[$];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic r, input logic wr, input logic [31:0] din, input logic ri,
                           input logic [2:0] c, input logic ro, input logic v,
                           input logic [31:0] d, input logic ov);
        vec_t t;
        t.r = r; t.wr = wr; t.din = din; t.ri = ri;
        t.e_cnt = c; t.e_ro = ro; t.e_v = v; t.e_dat = d; t.e_ov = ov;
        tbl.push_back(t);
    endtask

    initial begin
        rst = 1'b0; rst_m = 1'b0;
        lk.wr_en = 1'b0; lk.data_in = '0; lk.ready_in = 1'b0;
        lk_m.wr_en = 1'b0; lk_m.data_in = '0; lk_m.ready_in = 1'b0;

        // reset held with writes pending, then release
        add_vec(L0, L1, 32'h11, L0, 3'd0, L0, L0, 32'h0,  L0);
        add_vec(L0, L1, 32'h12, L0, 3'd0, L0, L0, 32'h0,  L0);
        add_vec(L0, L1, 32'h13, L0, 3'd0, L0, L0, 32'h0,  L0);
        add_vec(L1, L0, 32'h0,  L0, 3'd0, L1, L0, 32'h0,  L0);
        // fill to full then drain in order
        add_vec(L1, L1, 32'hA0, L0, 3'd1, L1, L1, 32'hA0, L0);
        add_vec(L1, L1, 32'hA1, L0, 3'd2, L1, L1, 32'hA0, L0);
        add_vec(L1, L1, 32'hA2, L0, 3'd3, L1, L1, 32'hA0, L0);
        add_vec(L1, L1, 32'hA3, L0, 3'd4, L0, L1, 32'hA0, L0);
        add_vec(L1, L0, 32'h0,  L1, 3'd3, L1, L1, 32'hA1, L0);
        add_vec(L1, L0, 32'h0,  L1, 3'd2, L1, L1, 32'hA2, L0);
        add_vec(L1, L0, 32'h0,  L1, 3'd1, L1, L1, 32'hA3, L0);
        add_vec(L1, L0, 32'h0,  L1, 3'd0, L1, L0, 32'h0,  L0);
        add_vec(L1, L0, 32'h0,  L1, 3'd0, L1, L0, 32'h0,  L0);
        // refill, then write while full with a simultaneous read
        add_vec(L1, L1, 32'hB0, L0, 3'd1, L1, L1, 32'hB0, L0);
        add_vec(L1, L1, 32'hB1, L0, 3'd2, L1, L1, 32'hB0, L0);
        add_vec(L1, L1, 32'hB2, L0, 3'd3, L1, L1, 32'hB0, L0);
        add_vec(L1, L1, 32'hB3, L0, 3'd4, L0, L1, 32'hB0, L0);
        add_vec(L1, L1, 32'hFF, L1, 3'd3, L1, L1, 32'hB1, L1);
        add_vec(L1, L0, 32'h0,  L0, 3'd3, L1, L1, 32'hB1, L1);

        for (int i = 0; i < tbl.size(); i++) begin
            rst         = tbl[i].r;
            lk.wr_en    = tbl[i].wr;
            lk.data_in  = tbl[i].din;
            lk.ready_in = tbl[i].ri;
            step();
            chk($sformatf("v%0d count", i),     {29'd0, cnt},           {29'd0, tbl[i].e_cnt});
            chk($sformatf("v%0d ready_out", i), {31'd0, lk.ready_out}, {31'd0, tbl[i].e_ro});
            chk($sformatf("v%0d valid_out", i), {31'd0, lk.valid_out}, {31'd0, tbl[i].e_v});
            chk($sformatf("v%0d overflow", i),  {31'd0, ovf},           {31'd0, tbl[i].e_ov});
            if (tbl[i].e_v) begin
                chk($sformatf("v%0d data_out", i), lk.data_out, tbl[i].e_dat);
            end
        end

        // mid-operation reset with count=3
        rst = 1'b0; lk.wr_en = 1'b1; lk.data_in = 32'hEE; lk.ready_in = 1'b0;
        step();
        chk("midrst count", {29'd0, cnt}, 32'd0);
        chk("midrst valid", {31'd0, lk.valid_out}, 32'd0);
        chk("midrst ready", {31'd0, lk.ready_out}, 32'd0);
        chk("midrst ovf",   {31'd0, ovf}, 32'd0);
        rst = 1'b1; lk.wr_en = 1'b0;
        step();
        chk("midrst ready rise", {31'd0, lk.ready_out}, 32'd1);
        lk.wr_en = 1'b1; lk.data_in = 32'hC5;
        step();
        lk.wr_en = 1'b0;
        chk("midrst first data", lk.data_out, 32'hC5);
        chk("midrst first cnt",  {29'd0, cnt}, 32'd1);
        lk.ready_in = 1'b1;
        step();
        lk.ready_in = 1'b0;
        chk("midrst drained", {31'd0, lk.valid_out}, 32'd0);

        // streaming at count=2 across pointer wraps
        lk.wr_en = 1'b1; lk.data_in = 32'hD0; q.push_back(32'hD0);
        step();
        lk.data_in = 32'hD1; q.push_back(32'hD1);
        step();
        chk("stream prefill cnt", {29'd0, cnt}, 32'd2);
        for (int i = 0; i < 20; i++) begin
            lk.wr_en    = 1'b1;
            lk.ready_in = 1'b1;
            lk.data_in  = 32'hD2 + 32'(i);
            chk($sformatf("stream%0d data", i),  lk.data_out, q[0]);
            chk($sformatf("stream%0d valid", i), {31'd0, lk.valid_out}, 32'd1);
            step();
            void'(q.pop_front());
            q.push_back(32'hD2 + 32'(i));
            chk($sformatf("stream%0d cnt", i), {29'd0, cnt}, 32'd2);
        end
        lk.wr_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("stream tail%0d", i), lk.data_out, q[0]);
            step();
            void'(q.pop_front());
        end
        lk.ready_in = 1'b0;
        chk("stream empty", {31'd0, lk.valid_out}, 32'd0);

        // margin instance: ready_out drops one slot early
        rst_m = 1'b1;
        step();
        chk("m ready rise", {31'd0, lk_m.ready_out}, 32'd1);
        lk_m.wr_en = 1'b1; lk_m.data_in = 32'h51;
        step();
        chk("m cnt1 ready", {31'd0, lk_m.ready_out}, 32'd1);
        lk_m.data_in = 32'h52;
        step();
        chk("m cnt2 ready", {31'd0, lk_m.ready_out}, 32'd1);
        lk_m.data_in = 32'h53;
        step();
        lk_m.wr_en = 1'b0;
        chk("m cnt3", {29'd0, cnt_m}, 32'd3);
        chk("m cnt3 ready", {31'd0, lk_m.ready_out}, 32'd0);
        chk("m head", lk_m.data_out, 32'h51);
        lk_m.ready_in = 1'b1;
        step();
        lk_m.ready_in = 1'b0;
        chk("m after read ready", {31'd0, lk_m.ready_out}, 32'd1);
        chk("m after read cnt", {29'd0, cnt_m}, 32'd2);
        chk("m after read head", lk_m.data_out, 32'h52);
        chk("m overflow", {31'd0, ovf_m}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
